// File: rtl/ipc_pkg.sv
// ipc_pkg
// Shared constants and types for the IPC buffer arbiter:
//   IPC_ADDR_W / IPC_DEPTH / IPC_DATA_W  - array geometry (512 x 8)
//   IPC_DB_HOST_ADDR / IPC_DB_MCU_ADDR   - doorbell byte addresses
//   port_e                               - requester select (Host / Mcu)
//   other_port()                         - round-robin pointer helper
package ipc_pkg;

    localparam int IPC_ADDR_W = 9;
    localparam int IPC_DEPTH  = 512;
    localparam int IPC_DATA_W = 8;

    localparam logic [IPC_ADDR_W-1:0] IPC_DB_HOST_ADDR = 9'h1FE;
    localparam logic [IPC_ADDR_W-1:0] IPC_DB_MCU_ADDR  = 9'h1FF;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_MCU  = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_HOST) ? PORT_MCU : PORT_HOST;
    endfunction

endpackage

// File: rtl/ipc_ram_array.sv
// ipc_ram_array
// Synchronous single-port 512x8 block RAM, read-before-write, registered
// read data. Contents start at zero from configuration and are never
// cleared by reset.
// Ports:
//   clk_i    system clock
//   en_i     access enable (read or write this cycle)
//   we_i     write enable (qualified by en_i)
//   addr_i   byte address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after an enabled read
module ipc_ram_array
    import ipc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [IPC_ADDR_W-1:0] addr_i,
    input  logic [IPC_DATA_W-1:0] wdata_i,
    output logic [IPC_DATA_W-1:0] rdata_o
);

    // Power-up contents are zero; a declaration initialiser maps onto the
    // block-RAM init image rather than any reset logic.
    logic [IPC_DATA_W-1:0] mem_q [IPC_DEPTH] = '{default: '0};
    logic [IPC_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ipc_ram_arbiter.sv
// ipc_ram_arbiter
// Round-robin arbiter serialising single-byte Host and Mcu requests onto one
// single-port 512x8 array. A grant in cycle N produces a one-cycle ack in
// N+1 with read data valid alongside; a port is not eligible during its own
// ack cycle, so each port gets at most one access every two cycles.
// Optional build macro IPC_DOORBELL_EN: writes to 0x1FF / 0x1FE set or
// clear the Mcu / Host doorbell flags; without it both irq outputs are 0.
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   host_req_i/we_i/addr_i/wdata_i      Host request and operands
//   host_ack_o, host_rdata_o            Host completion pulse, read data
//   mcu_req_i/we_i/addr_i/wdata_i       Mcu request and operands
//   mcu_ack_o, mcu_rdata_o              Mcu completion pulse, read data
//   irq_host_o, irq_mcu_o               doorbell pending flags
module ipc_ram_arbiter
    import ipc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [IPC_ADDR_W-1:0] host_addr_i,
    input  logic [IPC_DATA_W-1:0] host_wdata_i,
    output logic                  host_ack_o,
    output logic [IPC_DATA_W-1:0] host_rdata_o,

    input  logic                  mcu_req_i,
    input  logic                  mcu_we_i,
    input  logic [IPC_ADDR_W-1:0] mcu_addr_i,
    input  logic [IPC_DATA_W-1:0] mcu_wdata_i,
    output logic                  mcu_ack_o,
    output logic [IPC_DATA_W-1:0] mcu_rdata_o,

    output logic                  irq_host_o,
    output logic                  irq_mcu_o
);

    port_e                 ptr_q, ptr_d;
    logic                  host_ack_q, host_ack_d;
    logic                  mcu_ack_q, mcu_ack_d;
    logic                  host_rd_q, host_rd_d;
    logic                  mcu_rd_q, mcu_rd_d;
    logic [IPC_DATA_W-1:0] host_hold_q, host_hold_d;
    logic [IPC_DATA_W-1:0] mcu_hold_q, mcu_hold_d;

    logic                  host_elig, mcu_elig;
    logic                  grant_valid;
    port_e                 grant_port;
    logic                  g_we;
    logic [IPC_ADDR_W-1:0] g_addr;
    logic [IPC_DATA_W-1:0] g_wdata;

    logic                  ram_en, ram_we;
    logic [IPC_DATA_W-1:0] ram_rdata;

    // A port in its ack cycle may already be presenting its next request;
    // masking it here is what enforces the one-access-per-two-cycles rate.
    assign host_elig = host_req_i & ~host_ack_q;
    assign mcu_elig  = mcu_req_i  & ~mcu_ack_q;

    always_comb begin
        grant_valid = host_elig | mcu_elig;
        grant_port  = ptr_q;
        if (host_elig && !mcu_elig) begin
            grant_port = PORT_HOST;
        end else if (mcu_elig && !host_elig) begin
            grant_port = PORT_MCU;
        end
    end

    always_comb begin
        g_we    = host_we_i;
        g_addr  = host_addr_i;
        g_wdata = host_wdata_i;
        if (grant_port == PORT_MCU) begin
            g_we    = mcu_we_i;
            g_addr  = mcu_addr_i;
            g_wdata = mcu_wdata_i;
        end
    end

    // An access granted while reset is high is dropped outright, including
    // its array write.
    assign ram_en = grant_valid & ~reset_i;
    assign ram_we = ram_en & g_we;

    ipc_ram_array u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (g_addr),
        .wdata_i (g_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        ptr_d       = ptr_q;
        host_ack_d  = grant_valid && (grant_port == PORT_HOST);
        mcu_ack_d   = grant_valid && (grant_port == PORT_MCU);
        host_rd_d   = host_ack_d && !g_we;
        mcu_rd_d    = mcu_ack_d  && !g_we;
        host_hold_d = host_hold_q;
        mcu_hold_d  = mcu_hold_q;
        if (grant_valid) begin
            ptr_d = other_port(grant_port);
        end
        // Latch the array word at the end of the ack cycle so the value
        // persists until the port's next read completes.
        if (host_rd_q) begin
            host_hold_d = ram_rdata;
        end
        if (mcu_rd_q) begin
            mcu_hold_d = ram_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= PORT_HOST;
            host_ack_q  <= 1'b0;
            mcu_ack_q   <= 1'b0;
            host_rd_q   <= 1'b0;
            mcu_rd_q    <= 1'b0;
            host_hold_q <= '0;
            mcu_hold_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            host_ack_q  <= host_ack_d;
            mcu_ack_q   <= mcu_ack_d;
            host_rd_q   <= host_rd_d;
            mcu_rd_q    <= mcu_rd_d;
            host_hold_q <= host_hold_d;
            mcu_hold_q  <= mcu_hold_d;
        end
    end

    assign host_ack_o = host_ack_q;
    assign mcu_ack_o  = mcu_ack_q;

    // In a read's ack cycle the array output register already holds the
    // word; afterwards the per-port hold register carries it. Both sides of
    // the mux are flops, so the output stays glitch-free.
    assign host_rdata_o = host_rd_q ? ram_rdata : host_hold_q;
    assign mcu_rdata_o  = mcu_rd_q  ? ram_rdata : mcu_hold_q;

`ifdef IPC_DOORBELL_EN
    logic irq_host_q, irq_host_d;
    logic irq_mcu_q, irq_mcu_d;

    // Only one port is granted per cycle, so set and clear never collide.
    always_comb begin
        irq_host_d = irq_host_q;
        irq_mcu_d  = irq_mcu_q;
        if (grant_valid && g_we) begin
            if (g_addr == IPC_DB_MCU_ADDR) begin
                irq_mcu_d = (grant_port == PORT_HOST);
            end
            if (g_addr == IPC_DB_HOST_ADDR) begin
                irq_host_d = (grant_port == PORT_MCU);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_host_q <= 1'b0;
            irq_mcu_q  <= 1'b0;
        end else begin
            irq_host_q <= irq_host_d;
            irq_mcu_q  <= irq_mcu_d;
        end
    end

    assign irq_host_o = irq_host_q;
    assign irq_mcu_o  = irq_mcu_q;
`else
    assign irq_host_o = 1'b0;
    assign irq_mcu_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ipc_ram_arbiter.sv
module tb_ipc_ram_arbiter;

`ifdef IPC_DOORBELL_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       h_req, h_we, m_req, m_we;
    logic [8:0] h_addr, m_addr;
    logic [7:0] h_wd, m_wd;
    logic       h_ack, m_ack, irq_h, irq_m;
    logic [7:0] h_rd, m_rd;

    ipc_ram_arbiter dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .host_req_i   (h_req),
        .host_we_i    (h_we),
        .host_addr_i  (h_addr),
        .host_wdata_i (h_wd),
        .host_ack_o   (h_ack),
        .host_rdata_o (h_rd),
        .mcu_req_i    (m_req),
        .mcu_we_i     (m_we),
        .mcu_addr_i   (m_addr),
        .mcu_wdata_i  (m_wd),
        .mcu_ack_o    (m_ack),
        .mcu_rdata_o  (m_rd),
        .irq_host_o   (irq_h),
        .irq_mcu_o    (irq_m)
    );

    typedef struct {
        bit         idle;
        bit         we;
        logic [8:0] addr;
        logic [7:0] d;
    } txn_t;

    txn_t hq[$];
    txn_t mq[$];
    bit   h_busy = 0, m_busy = 0;
    bit   rst_next = 0;

    // reference model: byte array, pointer, expected outputs for next cycle
    logic [7:0] mem [512];
    bit         e_ack [2];
    logic [7:0] e_rd [2];
    bit         e_irq_h, e_irq_m;
    int         ptr;

    int errors = 0, checks = 0;
    int cyc = 0, n_hack = 0, n_mack = 0, n_both = 0;
    int hack_cyc = 0, mack_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("host_ack", h_ack, e_ack[0]);
        chk("mcu_ack", m_ack, e_ack[1]);
        chk("host_rdata", h_rd, e_rd[0]);
        chk("mcu_rdata", m_rd, e_rd[1]);
        chk("irq_host", irq_h, e_irq_h);
        chk("irq_mcu", irq_m, e_irq_m);
        if (h_ack === 1'b1) begin n_hack++; hack_cyc = cyc; end
        if (m_ack === 1'b1) begin n_mack++; mack_cyc = cyc; end
        if (h_ack === 1'b1 && m_ack === 1'b1) n_both++;
    endtask

    task automatic drive_ports();
        if (h_busy && e_ack[0]) begin void'(hq.pop_front()); h_busy = 0; end
        h_req = 0;
        if (!h_busy && hq.size() > 0 && hq[0].idle) void'(hq.pop_front());
        else if (hq.size() > 0) begin
            h_req = 1; h_we = hq[0].we; h_addr = hq[0].addr; h_wd = hq[0].d; h_busy = 1;
        end
        if (m_busy && e_ack[1]) begin void'(mq.pop_front()); m_busy = 0; end
        m_req = 0;
        if (!m_busy && mq.size() > 0 && mq[0].idle) void'(mq.pop_front());
        else if (mq.size() > 0) begin
            m_req = 1; m_we = mq[0].we; m_addr = mq[0].addr; m_wd = mq[0].d; m_busy = 1;
        end
    endtask

    // Apply the arbitration rules to the inputs of the current cycle.
    task automatic model_step();
        bit el0, el1, we;
        int g;
        logic [8:0] a;
        logic [7:0] d;
        el0 = h_req && !e_ack[0];
        el1 = m_req && !e_ack[1];
        g = -1;
        if (el0 && el1) g = ptr;
        else if (el0) g = 0;
        else if (el1) g = 1;
        if (rst) begin
            e_ack[0] = 0; e_ack[1] = 0; e_rd[0] = 8'h00; e_rd[1] = 8'h00;
            e_irq_h = 0; e_irq_m = 0; ptr = 0;
        end else begin
            e_ack[0] = (g == 0);
            e_ack[1] = (g == 1);
            if (g >= 0) begin
                we = (g == 0) ? h_we : m_we;
                a  = (g == 0) ? h_addr : m_addr;
                d  = (g == 0) ? h_wd : m_wd;
                if (!we) e_rd[g] = mem[a];
                else begin
                    mem[a] = d;
                    if (DB && a == 9'h1FF) e_irq_m = (g == 0);
                    if (DB && a == 9'h1FE) e_irq_h = (g == 1);
                end
                ptr = 1 - g;
            end
        end
    endtask

    task automatic do_cycle();
        tick();
        drive_ports();
        rst = rst_next;
        rst_next = 0;
        model_step();
        if (rst) begin
            if (h_busy) begin void'(hq.pop_front()); h_busy = 0; end
            if (m_busy) begin void'(mq.pop_front()); m_busy = 0; end
        end
    endtask

    task automatic run(input int maxc, input bit rand_rst);
        int n;
        n = 0;
        while ((hq.size() > 0 || mq.size() > 0 || h_busy || m_busy) && n < maxc) begin
            if (rand_rst && $urandom_range(0, 149) == 0) rst_next = 1;
            do_cycle();
            n++;
        end
        chk("drain_left", hq.size() + mq.size(), 0);
    endtask

    function automatic txn_t mk(input bit we, input logic [8:0] a, input logic [7:0] d);
        txn_t t;
        t.idle = 0; t.we = we; t.addr = a; t.d = d;
        return t;
    endfunction

    task automatic reset_pulse();
        rst_next = 1;
        do_cycle();
        do_cycle();
    endtask

    initial begin
        int bh, bm, bb;
        txn_t t;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rst = 1; h_req = 0; h_we = 0; h_addr = '0; h_wd = '0;
        m_req = 0; m_we = 0; m_addr = '0; m_wd = '0;
        @(negedge clk);
        model_step();
        do_cycle();
        do_cycle();

        // Host write then read, Mcu silent
        bm = n_mack;
        hq.push_back(mk(1, 9'h010, 8'hA5));
        hq.push_back(mk(0, 9'h010, 8'h00));
        run(50, 0);
        do_cycle();
        chk("tp1_rdata", h_rd, 8'hA5);
        chk("tp1_no_mcu_ack", n_mack - bm, 0);

        // simultaneous same-address writes, pointer at Host after reset
        reset_pulse();
        hq.push_back(mk(1, 9'h020, 8'h11));
        mq.push_back(mk(1, 9'h020, 8'h22));
        run(50, 0);
        chk("tp2_order", mack_cyc - hack_cyc, 1);
        hq.push_back(mk(0, 9'h020, 8'h00));
        run(50, 0);
        do_cycle();
        chk("tp2_rdata", h_rd, 8'h22);

        // sustained contention, 10 accesses each
        bh = n_hack; bm = n_mack; bb = n_both;
        for (int i = 0; i < 10; i++) begin
            hq.push_back(mk(i[0], 9'(9'h100 + i), 8'(i)));
            mq.push_back(mk(!i[0], 9'(9'h140 + i), 8'(8'h80 + i)));
        end
        run(100, 0);
        chk("tp3_host_acks", n_hack - bh, 10);
        chk("tp3_mcu_acks", n_mack - bm, 10);
        chk("tp3_both_acks", n_both - bb, 0);

        // reset lands on the Mcu write grant
        do_cycle();
        mq.push_back(mk(1, 9'h030, 8'h7E));
        rst_next = 1;
        bm = n_mack;
        do_cycle();
        do_cycle();
        do_cycle();
        chk("tp4_no_ack", n_mack - bm, 0);
        chk("tp4_rdata_zero", m_rd, 8'h00);
        mq.push_back(mk(0, 9'h030, 8'h00));
        run(50, 0);
        chk("tp4_read", m_rd, 8'h00);

        // doorbells
        hq.push_back(mk(1, 9'h1FF, 8'h01)); run(50, 0);
        chk("db_mcu_set", irq_m, DB);
        mq.push_back(mk(1, 9'h1FF, 8'h00)); run(50, 0);
        chk("db_mcu_clr", irq_m, 0);
        mq.push_back(mk(1, 9'h1FE, 8'h5A)); run(50, 0);
        chk("db_host_set", irq_h, DB);
        hq.push_back(mk(1, 9'h1FE, 8'h00)); run(50, 0);
        chk("db_host_clr", irq_h, 0);
        hq.push_back(mk(1, 9'h1FF, 8'h3C));
        hq.push_back(mk(0, 9'h1FF, 8'h00));
        run(50, 0);
        chk("db_read_1ff", h_rd, 8'h3C);
        chk("db_mcu_again", irq_m, DB);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            t.idle = ($urandom_range(0, 3) == 0);
            t.we   = $urandom_range(0, 1);
            t.addr = $urandom_range(0, 1) ? 9'(9'h1FC + $urandom_range(0, 3))
                                          : 9'($urandom_range(0, 511));
            t.d    = 8'($urandom_range(0, 255));
            if (i[0]) hq.push_back(t); else mq.push_back(t);
        end
        run(5000, 1);
        do_cycle();
        do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
